// File: rtl/morse_rx.sv
// Morse line decoder: times marks and gaps in PRESCALER units and emits ASCII strobes.
// Optional MORSE_RX_SYNC_EN adds a 2-flop input synchronizer (+2 cycles latency).
module morse_rx #(
    parameter int PRESCALER = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       morse_in,
    output logic [7:0] ascii_out,
    output logic       ascii_valid,
    output logic       err
);

    localparam int CMAX = 8 * PRESCALER;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] C_ONE    = CW'(1);
    localparam logic [CW-1:0] C_MAX    = CW'(CMAX);
    localparam logic [CW-1:0] C_GLITCH = CW'(PRESCALER / 2);
    localparam logic [CW-1:0] C_2U     = CW'(2 * PRESCALER);
    localparam logic [CW-1:0] C_5U     = CW'(5 * PRESCALER);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_MARK    = 3'd1;
    localparam logic [2:0] S_SYM_GAP = 3'd2;
    localparam logic [2:0] S_CHR_GAP = 3'd3;
    localparam logic [2:0] S_STUCK   = 3'd4;

    logic line_q;

`ifdef MORSE_RX_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
            line_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], morse_in};
            line_q <= sync_q[1];
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) line_q <= 1'b0;
        else     line_q <= morse_in;
    end
`endif

    logic [2:0]    state;
    logic          lvl;
    logic [CW-1:0] cnt;
    logic [CW-1:0] run;
    logic [2:0]    sym_len;
    logic [5:0]    sym_pat;
    logic          sym_ovf;
    logic          word;

    // run = length of the current level including this sample
    always_comb begin
        if (line_q != lvl)   run = C_ONE;
        else if (cnt == C_MAX) run = C_MAX;
        else                 run = cnt + C_ONE;
    end

    logic rise, fall, glitch, is_dash;
    assign rise    = line_q && !lvl;
    assign fall    = !line_q && lvl;
    assign glitch  = cnt < C_GLITCH;
    assign is_dash = cnt >= C_2U;

    function automatic logic [7:0] decode(input logic [2:0] len,
                                          input logic [5:0] pat);
        logic [7:0] ch;
        ch = 8'h3F;
        case ({len, pat})
            {3'd1, 6'b000000}: ch = "E";
            {3'd1, 6'b000001}: ch = "T";
            {3'd2, 6'b000000}: ch = "I";
            {3'd2, 6'b000001}: ch = "A";
            {3'd2, 6'b000010}: ch = "N";
            {3'd2, 6'b000011}: ch = "M";
            {3'd3, 6'b000000}: ch = "S";
            {3'd3, 6'b000001}: ch = "U";
            {3'd3, 6'b000010}: ch = "R";
            {3'd3, 6'b000011}: ch = "W";
            {3'd3, 6'b000100}: ch = "D";
            {3'd3, 6'b000101}: ch = "K";
            {3'd3, 6'b000110}: ch = "G";
            {3'd3, 6'b000111}: ch = "O";
            {3'd4, 6'b000000}: ch = "H";
            {3'd4, 6'b000001}: ch = "V";
            {3'd4, 6'b000010}: ch = "F";
            {3'd4, 6'b000100}: ch = "L";
            {3'd4, 6'b000110}: ch = "P";
            {3'd4, 6'b000111}: ch = "J";
            {3'd4, 6'b001000}: ch = "B";
            {3'd4, 6'b001001}: ch = "X";
            {3'd4, 6'b001010}: ch = "C";
            {3'd4, 6'b001011}: ch = "Y";
            {3'd4, 6'b001100}: ch = "Z";
            {3'd4, 6'b001101}: ch = "Q";
            {3'd5, 6'b000000}: ch = "5";
            {3'd5, 6'b000001}: ch = "4";
            {3'd5, 6'b000011}: ch = "3";
            {3'd5, 6'b000111}: ch = "2";
            {3'd5, 6'b001111}: ch = "1";
            {3'd5, 6'b010000}: ch = "6";
            {3'd5, 6'b011000}: ch = "7";
            {3'd5, 6'b011100}: ch = "8";
            {3'd5, 6'b011110}: ch = "9";
            {3'd5, 6'b011111}: ch = "0";
            default:           ch = 8'h3F;
        endcase
        return ch;
    endfunction

    logic [7:0] letter;
    assign letter = sym_ovf ? 8'h3F : decode(sym_len, sym_pat);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            lvl         <= 1'b0;
            cnt         <= '0;
            sym_len     <= 3'd0;
            sym_pat     <= 6'd0;
            sym_ovf     <= 1'b0;
            word        <= 1'b0;
            ascii_out   <= 8'h00;
            ascii_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            lvl         <= line_q;
            cnt         <= run;
            ascii_valid <= 1'b0;
            err         <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rise) state <= S_MARK;
                end
                S_MARK: begin
                    if (fall) begin
                        if (!glitch) begin
                            if (sym_len == 3'd6) begin
                                sym_ovf <= 1'b1;
                            end else begin
                                sym_pat <= {sym_pat[4:0], is_dash};
                                sym_len <= sym_len + 3'd1;
                            end
                            state <= S_SYM_GAP;
                        end else if (sym_len != 3'd0) begin
                            state <= S_SYM_GAP;
                        end else if (word) begin
                            // glitch after a letter: keep waiting for the word gap
                            state <= S_CHR_GAP;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (run == C_MAX) begin
                        err     <= 1'b1;
                        sym_len <= 3'd0;
                        sym_pat <= 6'd0;
                        sym_ovf <= 1'b0;
                        word    <= 1'b0;
                        state   <= S_STUCK;
                    end
                end
                S_SYM_GAP: begin
                    if (rise) begin
                        state <= S_MARK;
                    end else if (sym_len == 3'd0) begin
                        state <= S_IDLE;
                    end else if (run == C_2U) begin
                        ascii_out   <= letter;
                        ascii_valid <= 1'b1;
                        err         <= (letter == 8'h3F);
                        word        <= 1'b1;
                        sym_len     <= 3'd0;
                        sym_pat     <= 6'd0;
                        sym_ovf     <= 1'b0;
                        state       <= S_CHR_GAP;
                    end
                end
                S_CHR_GAP: begin
                    if (rise) begin
                        state <= S_MARK;
                    end else if (run == C_5U) begin
                        ascii_out   <= 8'h20;
                        ascii_valid <= 1'b1;
                        word        <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                S_STUCK: begin
                    if (!line_q) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
